// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed two-digit 7-segment driver: per-frame snapshot of the BCD digits,
// blank gaps between digits, optional leading-zero blanking and pin polarity control.
module bcd_7seg_scan_driver #(
    parameter int REFRESH_DIV    = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit1,
    input  logic [3:0] digit0,
    input  logic       lzb_en,
    input  logic       enable,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam int MAX_LEN = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int TW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        BLANK0 = 2'd0,
        SHOW0  = 2'd1,
        BLANK1 = 2'd2,
        SHOW1  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt, last_cnt;
    logic [3:0]    snap1, snap0;
    logic          snap_lzb;
    logic          en_q;
    logic          snap_take;
    logic [6:0]    seg_l;
    logic [1:0]    an_l;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'h3F;
            4'd1:    dec7 = 7'h06;
            4'd2:    dec7 = 7'h5B;
            4'd3:    dec7 = 7'h4F;
            4'd4:    dec7 = 7'h66;
            4'd5:    dec7 = 7'h6D;
            4'd6:    dec7 = 7'h7D;
            4'd7:    dec7 = 7'h07;
            4'd8:    dec7 = 7'h7F;
            4'd9:    dec7 = 7'h6F;
            default: dec7 = 7'h40;
        endcase
    endfunction

    // enable is registered so every output is a pure decode of flops
    always_ff @(posedge clk) begin
        en_q <= enable;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BLANK0;
            timer    <= '0;
            snap1    <= 4'd0;
            snap0    <= 4'd0;
            snap_lzb <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            if (snap_take) begin
                snap1    <= digit1;
                snap0    <= digit0;
                snap_lzb <= lzb_en;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        last_cnt  = (state == SHOW0 || state == SHOW1) ? TW'(REFRESH_DIV - 1)
                                                        : TW'(BLANK_CYCLES - 1);
        snap_take = en_q && (state == BLANK0) && (timer == '0);
        if (en_q) begin
            if (timer == last_cnt) begin
                timer_nxt = '0;
                case (state)
                    BLANK0:  state_nxt = SHOW0;
                    SHOW0:   state_nxt = BLANK1;
                    BLANK1:  state_nxt = SHOW1;
                    default: state_nxt = BLANK0;
                endcase
            end else begin
                timer_nxt = timer + TW'(1);
            end
        end
    end

    always_comb begin
        an_l  = 2'b00;
        seg_l = 7'h00;
        if (en_q) begin
            if (state == SHOW0) begin
                an_l  = 2'b01;
                seg_l = dec7(snap0);
            end else if (state == SHOW1 && !(snap_lzb && snap1 == 4'd0)) begin
                an_l  = 2'b10;
                seg_l = dec7(snap1);
            end
        end
        seg        = seg_l ^ {7{SEG_ACTIVE_LOW}};
        an         = an_l ^ {2{AN_ACTIVE_LOW}};
        frame_tick = snap_take;
    end

endmodule
